// File: rtl/shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module   : shift_rows_stream
// Purpose  : Byte-serial AES ShiftRows/InvShiftRows with ping-pong banks and
//            valid/ready on both sides. SHIFTROWS_BYPASS_EN adds a bypass port.
// Revision : 1.0
// ============================================================================
module shift_rows_stream #(
  parameter int WORD_W = 8,
  parameter int NCOL   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inverse,
`ifdef SHIFTROWS_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int               NB       = 4 * NCOL;
  localparam int               IDX_W    = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [31:0]      NCOL_U   = 32'(NCOL);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  logic [WORD_W-1:0] mem_q [2][NB];
  logic [1:0]        full;
  logic [1:0]        inv_q, inv_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic              rst_done_q;
  logic              in_fire, out_fire, wr_last, rd_last;
  logic [IDX_W-1:0]  rd_addr;
  logic [31:0]       row, col, rot, src_col;
`ifdef SHIFTROWS_BYPASS_EN
  logic [1:0]        byp_q, byp_d;
`endif

  assign in_ready  = rst_done_q & ~full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign out_last  = out_valid & (rd_idx_q == LAST_IDX);
  assign out_data  = mem_q[rd_bank_q][rd_addr];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign wr_last  = (wr_idx_q == LAST_IDX);
  assign rd_last  = (rd_idx_q == LAST_IDX);

  // Row r of the output is row r of the stored block rotated by r columns.
  always_comb begin
    row = 32'(rd_idx_q[1:0]);
    col = 32'(rd_idx_q >> 2);
    rot = row % NCOL_U;
    if (inv_q[rd_bank_q]) begin
      src_col = (col + NCOL_U - rot) % NCOL_U;
    end else begin
      src_col = (col + rot) % NCOL_U;
    end
    rd_addr = IDX_W'(row + 32'd4 * src_col);
`ifdef SHIFTROWS_BYPASS_EN
    if (byp_q[rd_bank_q]) begin
      rd_addr = rd_idx_q;
    end
`endif
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    inv_d     = inv_q;
`ifdef SHIFTROWS_BYPASS_EN
    byp_d     = byp_q;
`endif
    if (in_fire) begin
      if (wr_idx_q == '0) begin
        inv_d[wr_bank_q] = inverse;
`ifdef SHIFTROWS_BYPASS_EN
        byp_d[wr_bank_q] = bypass;
`endif
      end
      if (wr_last) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (out_fire) begin
      if (rd_last) begin
        rd_idx_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_idx_q   <= rd_idx_d;
      rd_bank_q  <= rd_bank_d;
      rst_done_q <= 1'b1;
    end
  end

  // Storage and latched modes carry no reset; they are only read while full.
  always_ff @(posedge clock) begin
    inv_q <= inv_d;
`ifdef SHIFTROWS_BYPASS_EN
    byp_q <= byp_d;
`endif
    if (in_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [1:0] st_q, st_d;
    logic       wr_sel, rd_sel;

    assign wr_sel = in_fire  & (wr_bank_q == 1'(b));
    assign rd_sel = out_fire & (rd_bank_q == 1'(b));

    always_ff @(posedge clock) begin
      if (!resetn) begin
        st_q <= ST_EMPTY;
      end else begin
        st_q <= st_d;
      end
    end

    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_EMPTY:    if (wr_sel) st_d = wr_last ? ST_FULL : ST_FILLING;
        ST_FILLING:  if (wr_sel && wr_last) st_d = ST_FULL;
        ST_FULL:     if (rd_sel) st_d = rd_last ? ST_EMPTY : ST_DRAINING;
        ST_DRAINING: if (rd_sel && rd_last) st_d = ST_EMPTY;
        default:     st_d = ST_EMPTY;
      endcase
    end

    assign full[b] = (st_q == ST_FULL) || (st_q == ST_DRAINING);
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rows_stream
// Purpose  : Randomised bench for shift_rows_stream with a row-rotation model.
// Revision : 1.0
// ============================================================================
module tb_shift_rows_stream;
  localparam int NB = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       inverse = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;
`ifdef SHIFTROWS_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  shift_rows_stream #(.WORD_W(8), .NCOL(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inverse   (inverse),
`ifdef SHIFTROWS_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rdy_mode = 0;
  int         acc_cnt = 0;
  int         first_out = -1;
  int         last_out = -1;
  logic [8:0] exp_q[$];
  logic [7:0] log_q[$];
  logic [8:0] mon_e;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [7:0] blk[NB];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: split block into rows, rotate each row r by r places, reassemble.
  function automatic void push_block(input logic [7:0] b[NB], input bit inv, input bit byp);
    logic [7:0] rw[4];
    logic [7:0] res[NB];
    logic [7:0] t;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) rw[c] = b[r + 4 * c];
      if (!byp) begin
        for (int k = 0; k < r; k++) begin
          if (!inv) begin
            t = rw[0]; rw[0] = rw[1]; rw[1] = rw[2]; rw[2] = rw[3]; rw[3] = t;
          end else begin
            t = rw[3]; rw[3] = rw[2]; rw[2] = rw[1]; rw[1] = rw[0]; rw[0] = t;
          end
        end
      end
      for (int c = 0; c < 4; c++) res[r + 4 * c] = rw[c];
    end
    for (int j = 0; j < NB; j++) exp_q.push_back({(j == NB - 1), res[j]});
  endfunction

  // Output side: pick out_ready, check held data stability and each transfer.
  always begin
    @(negedge clock);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (resetn) begin
      if (prev_hold) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", out_data, mon_e[7:0]);
          check_eq("out_last", out_last, mon_e[8]);
        end
        log_q.push_back(out_data);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic drive_word(input logic [7:0] d, input bit inv);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    inverse  = inv;
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) check_eq("in_timeout", in_ready, 1);
    @(negedge clock);
    acc_cnt++;
  endtask

  task automatic send_block(input bit inv, input bit byp, input int toggle_at, input int nwords);
    if (nwords == NB) push_block(blk, inv, byp);
`ifdef SHIFTROWS_BYPASS_EN
    bypass = byp;
`endif
    for (int i = 0; i < nwords; i++) begin
`ifdef SHIFTROWS_BYPASS_EN
      if (toggle_at >= 0 && i >= toggle_at) bypass = ~byp;
`endif
      drive_word(blk[i], (toggle_at >= 0 && i >= toggle_at) ? ~inv : inv);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    check_eq("idle_valid", out_valid, 0);
  endtask

  task automatic check_log(input string tag, input logic [127:0] ref_v, input int n);
    check_eq({tag, "_count"}, log_q.size(), NB);
    for (int i = 0; i < n && i < log_q.size(); i++)
      check_eq(tag, log_q[i], ref_v[127 - 8 * i -: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] fwd_ref, inv_ref, t5_ref, id_ref;
    fwd_ref = 128'h00050A0F_04090E03_080D0207_0C01060B;
    inv_ref = 128'h000D0A07_04010E0B_0805020F_0C090603;
    t5_ref  = 128'h10151A1F_00000000_00000000_00000000;
    id_ref  = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    resetn = 1'b1;
    @(negedge clock);
    check_eq("ready_after_rst", in_ready, 1);

    // Forward known vector with latency check
    rdy_mode = 0;
    log_q.delete();
    for (int i = 0; i < NB; i++) blk[i] = 8'(i);
    push_block(blk, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) check_eq("lat_before", out_valid, 0);
      drive_word(blk[i], 1'b0);
    end
    in_valid = 1'b0;
    check_eq("lat_after", out_valid, 1);
    check_eq("first_word", out_data, 8'h00);
    wait_drain();
    check_log("t1_fwd", fwd_ref, NB);

    // Inverse known vector
    log_q.delete();
    send_block(1'b1, 1'b0, -1, NB);
    in_valid = 1'b0;
    wait_drain();
    check_log("t2_inv", inv_ref, NB);

    // Back-to-back forward then inverse
    begin
      int c0;
      first_out = -1;
      c0 = cyc;
      send_block(1'b0, 1'b0, -1, NB);
      send_block(1'b1, 1'b0, -1, NB);
      in_valid = 1'b0;
      check_eq("t3_in_cycles", cyc - c0, 32);
      wait_drain();
      check_eq("t3_out_span", last_out - first_out, 31);
    end

    // Downstream stalled while three blocks are offered
    rdy_mode = 2;
    acc_cnt = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          for (int i = 0; i < NB; i++) blk[i] = 8'($urandom);
          send_block(1'($urandom), 1'b0, -1, NB);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (40) @(negedge clock);
        check_eq("t4_accepted", acc_cnt, 32);
        check_eq("t4_in_ready", in_ready, 0);
        rdy_mode = 1;
      end
    join
    wait_drain();

    // Reset in the middle of a block, then a fresh block
    rdy_mode = 0;
    for (int i = 0; i < NB; i++) blk[i] = 8'(8'hA0 + i);
    send_block(1'b0, 1'b0, -1, 7);
    resetn = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    check_eq("t5_rst_in_ready", in_ready, 0);
    check_eq("t5_rst_out_valid", out_valid, 0);
    resetn = 1'b1;
    @(negedge clock);
    log_q.delete();
    for (int i = 0; i < NB; i++) blk[i] = 8'(8'h10 + i);
    send_block(1'b0, 1'b0, -1, NB);
    in_valid = 1'b0;
    wait_drain();
    check_log("t5_fwd", t5_ref, 4);

    // Mode toggled mid-block is ignored
    for (int i = 0; i < NB; i++) blk[i] = 8'(i);
    send_block(1'b0, 1'b0, 5, NB);
    send_block(1'b1, 1'b0, 5, NB);
    in_valid = 1'b0;
    wait_drain();
`ifdef SHIFTROWS_BYPASS_EN
    log_q.delete();
    send_block(1'b0, 1'b1, 5, NB);
    in_valid = 1'b0;
    wait_drain();
    check_log("t6_bypass", id_ref, NB);
`endif

    // Random traffic with random backpressure and input gaps
    rdy_mode = 1;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NB; i++) blk[i] = 8'($urandom);
      send_block(1'($urandom), 1'b0, -1, NB);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clock);
      end
    end
    in_valid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
